flash_playback_ctrl: RTL and testbench

Sequences 32-bit word reads from the on-board flash over an Avalon-MM read master interface and turns them into a 16-bit audio sample stream, one sample per sample_tick. Each flash word holds two 16-bit samples. The block sits between the 22 kHz tick synchronizer, the keyboard/control decoder (play, dir, restart) and the flash controller. It owns the playback address counter, the direction and wrap policy, and the half-word selection.

---
 rtl/flash_playback_ctrl.sv | 129 ++++++++++++
 tb/tb_flash_playback_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_playback_ctrl.sv
// Flash playback controller: fetches 32-bit words from flash over an
// Avalon-MM read master and plays them back as two 16-bit samples per word,
// one sample per sample_tick, with forward/backward wrap and restart.
module flash_playback_ctrl #(
   parameter int                    ADDR_WIDTH = 23,
   parameter logic [ADDR_WIDTH-1:0] LAST_ADDR  = 23'h7FFFF
) (
   input  logic                  clk50M,
   input  logic                  reset,
   input  logic                  sample_tick,
   input  logic                  play,
   input  logic                  dir,
   input  logic                  restart,
   output logic                  flash_mem_read,
   output logic [ADDR_WIDTH-1:0] flash_mem_address,
   output logic [3:0]            flash_mem_byteenable,
   input  logic                  flash_mem_waitrequest,
   input  logic [31:0]           flash_mem_readdata,
   input  logic                  flash_mem_readdatavalid,
   output logic [15:0]           audio_sample,
   output logic                  sample_valid,
   output logic                  busy,
   output logic                  tick_overrun
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;

   logic [1:0]            state;
   logic [ADDR_WIDTH-1:0] addr;
   logic                  half_pending;
   logic                  word_dir;
   logic                  restart_pending;
   logic [31:0]           word;
   logic [ADDR_WIDTH-1:0] reload_addr;

   // Next address in the given direction, wrapping inside [0, LAST_ADDR].
   function automatic logic [ADDR_WIDTH-1:0] step_addr(input logic [ADDR_WIDTH-1:0] a,
                                                       input logic back);
      if (back)
         return (a == '0) ? LAST_ADDR : a - ADDR_WIDTH'(1);
      else
         return (a == LAST_ADDR) ? '0 : a + ADDR_WIDTH'(1);
   endfunction

   assign reload_addr          = dir ? LAST_ADDR : '0;
   assign flash_mem_address    = addr;
   assign flash_mem_byteenable = 4'hF;

   // Playback FSM: tick handling, Avalon read handshake, half-word selection
   // and address stepping. word_dir is frozen per word so a dir change while a
   // half is pending only affects the next fetch.
   always_ff @(posedge clk50M) begin
      if (reset) begin
         state           <= ST_IDLE;
         addr            <= '0;
         half_pending    <= 1'b0;
         word_dir        <= 1'b0;
         restart_pending <= 1'b0;
         word            <= '0;
         flash_mem_read  <= 1'b0;
         audio_sample    <= '0;
         sample_valid    <= 1'b0;
         busy            <= 1'b0;
         tick_overrun    <= 1'b0;
      end else begin
         sample_valid <= 1'b0;
         tick_overrun <= 1'b0;
         case (state)
            ST_IDLE: begin
               // restart wins over a coincident tick; that tick is simply lost
               if (restart) begin
                  addr         <= reload_addr;
                  half_pending <= 1'b0;
               end else if (sample_tick && play) begin
                  if (half_pending) begin
                     audio_sample <= word_dir ? word[15:0] : word[31:16];
                     sample_valid <= 1'b1;
                     half_pending <= 1'b0;
                     addr         <= step_addr(addr, word_dir);
                  end else begin
                     word_dir       <= dir;
                     flash_mem_read <= 1'b1;
                     busy           <= 1'b1;
                     state          <= ST_REQ;
                  end
               end
            end
            ST_REQ: begin
               if (restart)     restart_pending <= 1'b1;
               if (sample_tick) tick_overrun    <= 1'b1;
               // read and address stay put until the slave accepts
               if (!flash_mem_waitrequest) begin
                  flash_mem_read <= 1'b0;
                  state          <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (sample_tick) tick_overrun <= 1'b1;
               if (flash_mem_readdatavalid) begin
                  word  <= flash_mem_readdata;
                  busy  <= 1'b0;
                  state <= ST_IDLE;
                  if (restart_pending || restart) begin
                     // data from before the restart is stale: drop it
                     addr            <= reload_addr;
                     half_pending    <= 1'b0;
                     restart_pending <= 1'b0;
                  end else begin
                     audio_sample <= word_dir ? flash_mem_readdata[31:16]
                                              : flash_mem_readdata[15:0];
                     sample_valid <= 1'b1;
                     half_pending <= 1'b1;
                  end
               end else if (restart) begin
                  restart_pending <= 1'b1;
               end
            end
            default: begin
               state          <= ST_IDLE;
               flash_mem_read <= 1'b0;
               busy           <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_flash_playback_ctrl.sv
// Directed bench for flash_playback_ctrl: small Avalon flash model, expected
// samples queued at stimulus time and compared when sample_valid fires.
module tb_flash_playback_ctrl;

   localparam int          AW   = 23;
   localparam logic [AW-1:0] LAST = 23'h7FFFF;

   logic          clk50M = 1'b0;
   logic          reset = 1'b1;
   logic          sample_tick = 1'b0;
   logic          play = 1'b0;
   logic          dir = 1'b0;
   logic          restart = 1'b0;
   logic          flash_mem_read;
   logic [AW-1:0] flash_mem_address;
   logic [3:0]    flash_mem_byteenable;
   logic          flash_mem_waitrequest = 1'b0;
   logic [31:0]   flash_mem_readdata = '0;
   logic          flash_mem_readdatavalid = 1'b0;
   logic [15:0]   audio_sample;
   logic          sample_valid;
   logic          busy;
   logic          tick_overrun;

   flash_playback_ctrl #(.ADDR_WIDTH(AW), .LAST_ADDR(LAST)) dut (
      .clk50M                  (clk50M),
      .reset                   (reset),
      .sample_tick             (sample_tick),
      .play                    (play),
      .dir                     (dir),
      .restart                 (restart),
      .flash_mem_read          (flash_mem_read),
      .flash_mem_address       (flash_mem_address),
      .flash_mem_byteenable    (flash_mem_byteenable),
      .flash_mem_waitrequest   (flash_mem_waitrequest),
      .flash_mem_readdata      (flash_mem_readdata),
      .flash_mem_readdatavalid (flash_mem_readdatavalid),
      .audio_sample            (audio_sample),
      .sample_valid            (sample_valid),
      .busy                    (busy),
      .tick_overrun            (tick_overrun)
   );

   always #10 clk50M = ~clk50M;

   int          n_pass = 0;
   int          n_total = 0;
   int          n_sv = 0;
   int          n_ovr = 0;
   int          n_acc = 0;
   int          n_rdv = 0;
   int          lat = 2;
   int          lat_cnt = 0;
   logic [AW-1:0] acc_addr = '0;
   logic [31:0] pend = '0;
   logic [15:0] exp_q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
      if (a == '0)        return 32'hAAAA_5555;
      else if (a == LAST) return 32'h1234_5678;
      else                return {~a[15:0], a[15:0]};
   endfunction

   // flash slave: accepts when read & !waitrequest, returns data lat edges later
   initial forever begin
      @(posedge clk50M);
      flash_mem_readdatavalid <= 1'b0;
      if (lat_cnt != 0) begin
         lat_cnt <= lat_cnt - 1;
         if (lat_cnt == 1) begin
            flash_mem_readdatavalid <= 1'b1;
            flash_mem_readdata      <= pend;
            n_rdv                   <= n_rdv + 1;
         end
      end
      if (flash_mem_read && !flash_mem_waitrequest) begin
         pend     <= mem_word(flash_mem_address);
         acc_addr <= flash_mem_address;
         lat_cnt  <= lat;
         n_acc    <= n_acc + 1;
      end
   end

   // scoreboard side: pop one expected sample per sample_valid
   initial forever begin
      @(negedge clk50M);
      if (tick_overrun) n_ovr++;
      if (sample_valid) begin
         n_sv++;
         if (exp_q.size() == 0) chk("unexpected_sample", {31'b0, sample_valid}, 32'd0);
         else chk("sample", {16'b0, audio_sample}, {16'b0, exp_q.pop_front()});
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed no finish expected finish");
      $fatal(1, "watchdog");
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk50M);
   endtask

   task automatic do_tick();
      sample_tick = 1'b1;
      @(negedge clk50M);
      sample_tick = 1'b0;
   endtask

   task automatic wait_sample(input string tag, input int budget);
      int start;
      int i;
      start = n_sv;
      i = 0;
      while (n_sv == start && i < budget) begin
         @(negedge clk50M);
         i++;
      end
      chk({tag, "_arrived"}, {31'b0, n_sv != start}, 32'd1);
   endtask

   task automatic wait_idle(input int budget);
      int i;
      i = 0;
      while (busy && i < budget) begin
         @(negedge clk50M);
         i++;
      end
      chk("idle_reached", {31'b0, busy}, 32'd0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step(2);
      reset = 1'b0;
   endtask

   initial begin
      int sv0, ovr0, acc0, rdv0;
      step(3);
      // reset state
      chk("rst_read", {31'b0, flash_mem_read}, 32'd0);
      chk("rst_addr", {9'b0, flash_mem_address}, 32'd0);
      chk("rst_sample", {16'b0, audio_sample}, 32'd0);
      chk("rst_valid", {31'b0, sample_valid}, 32'd0);
      chk("rst_ovr", {31'b0, tick_overrun}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("byteenable", {28'b0, flash_mem_byteenable}, 32'hF);
      reset = 1'b0;
      step(1);

      // paused: ticks ignored
      do_tick();
      chk("pause_busy", {31'b0, busy}, 32'd0);
      chk("pause_ovr", {31'b0, tick_overrun}, 32'd0);
      step(2);

      // forward playback from address 0
      play = 1'b1;
      dir  = 1'b0;
      exp_q.push_back(16'h5555);
      do_tick();
      wait_sample("fwd_first", 40);
      chk("fwd_fetch_addr", {9'b0, acc_addr}, 32'd0);
      exp_q.push_back(16'hAAAA);
      do_tick();
      chk("half_latency", {31'b0, sample_valid}, 32'd1);
      chk("fwd_addr_step", {9'b0, flash_mem_address}, 32'd1);
      step(2);

      // backward: restart coincident with tick reloads to LAST, tick dropped
      do_reset();
      dir = 1'b1;
      restart = 1'b1;
      sample_tick = 1'b1;
      step(1);
      restart = 1'b0;
      sample_tick = 1'b0;
      chk("restart_addr", {9'b0, flash_mem_address}, {9'b0, LAST});
      chk("restart_tick_busy", {31'b0, busy}, 32'd0);
      chk("restart_tick_ovr", {31'b0, tick_overrun}, 32'd0);
      step(1);
      exp_q.push_back(16'h1234);
      do_tick();
      wait_sample("bwd_first", 40);
      chk("bwd_fetch_addr", {9'b0, acc_addr}, {9'b0, LAST});
      exp_q.push_back(16'h5678);
      do_tick();
      chk("bwd_addr_step", {9'b0, flash_mem_address}, {9'b0, LAST - 23'd1});
      step(2);

      // backward wrap from 0
      dir = 1'b0;
      restart = 1'b1;
      step(1);
      restart = 1'b0;
      chk("reload_zero", {9'b0, flash_mem_address}, 32'd0);
      dir = 1'b1;
      exp_q.push_back(16'hAAAA);
      do_tick();
      wait_sample("bwrap_first", 40);
      exp_q.push_back(16'h5555);
      do_tick();
      chk("bwd_wrap_addr", {9'b0, flash_mem_address}, 32'h7FFFF);
      step(2);

      // forward wrap at LAST
      dir = 1'b0;
      exp_q.push_back(16'h5678);
      do_tick();
      wait_sample("fwrap_first", 40);
      exp_q.push_back(16'h1234);
      do_tick();
      chk("fwd_wrap_addr", {9'b0, flash_mem_address}, 32'd0);
      step(2);

      // waitrequest stall with a tick arriving during REQ
      sv0  = n_sv;
      ovr0 = n_ovr;
      flash_mem_waitrequest = 1'b1;
      exp_q.push_back(16'h5555);
      do_tick();
      for (int i = 0; i < 5; i++) begin
         chk("stall_read", {31'b0, flash_mem_read}, 32'd1);
         chk("stall_addr", {9'b0, flash_mem_address}, 32'd0);
         if (i == 2) chk("stall_ovr_pulse", {31'b0, tick_overrun}, 32'd1);
         sample_tick = (i == 1);
         @(negedge clk50M);
      end
      sample_tick = 1'b0;
      flash_mem_waitrequest = 1'b0;
      wait_sample("stall", 40);
      step(4);
      chk("stall_ovr_count", ovr0 == n_ovr ? 32'd0 : n_ovr - ovr0, 32'd1);
      chk("stall_sv_count", n_sv - sv0, 32'd1);
      exp_q.push_back(16'hAAAA);
      do_tick();
      chk("stall_addr_step", {9'b0, flash_mem_address}, 32'd1);
      step(2);

      // restart while waiting for read data
      lat = 4;
      sv0 = n_sv;
      do_tick();
      step(1);
      chk("wait_busy", {31'b0, busy}, 32'd1);
      chk("wait_read_low", {31'b0, flash_mem_read}, 32'd0);
      restart = 1'b1;
      step(1);
      restart = 1'b0;
      wait_idle(40);
      step(3);
      chk("restart_no_sample", n_sv - sv0, 32'd0);
      chk("restart_wait_addr", {9'b0, flash_mem_address}, 32'd0);
      lat  = 2;
      acc0 = n_acc;
      exp_q.push_back(16'h5555);
      do_tick();
      wait_sample("post_restart", 40);
      chk("post_restart_fetch", {9'b0, acc_addr}, 32'd0);
      chk("post_restart_nacc", n_acc - acc0, 32'd1);
      exp_q.push_back(16'hAAAA);
      do_tick();
      chk("post_restart_step", {9'b0, flash_mem_address}, 32'd1);
      step(2);

      // reset asserted while in REQ, then a late readdatavalid
      flash_mem_waitrequest = 1'b1;
      do_tick();
      chk("req_read", {31'b0, flash_mem_read}, 32'd1);
      sv0  = n_sv;
      rdv0 = n_rdv;
      reset = 1'b1;
      flash_mem_waitrequest = 1'b0;
      step(1);
      chk("rreq_read", {31'b0, flash_mem_read}, 32'd0);
      chk("rreq_sample", {16'b0, audio_sample}, 32'd0);
      chk("rreq_addr", {9'b0, flash_mem_address}, 32'd0);
      chk("rreq_busy", {31'b0, busy}, 32'd0);
      reset = 1'b0;
      step(10);
      chk("late_rdv_seen", n_rdv - rdv0, 32'd1);
      chk("late_rdv_no_sample", n_sv - sv0, 32'd0);

      chk("queue_drained", exp_q.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
